// File: rtl/demux1x8_tdm.sv
// 1-to-8 TDM serial demultiplexer: routes valid serial bits to slots 0..7 and
// emits completed frames. Define DEMUX_PARITY_EN to add a 9th even-parity slot.
module demux1x8_tdm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sync,
  output logic [7:0] y,
  output logic [7:0] frame,
  output logic       frame_valid,
  output logic [2:0] slot,
  output logic       parity_err
);

`ifdef DEMUX_PARITY_EN
  localparam int unsigned SW = 4;
`else
  localparam int unsigned SW = 3;
`endif

  typedef enum logic [SW-1:0] {
    S0, S1, S2, S3, S4, S5, S6, S7
`ifdef DEMUX_PARITY_EN
    , SP
`endif
  } state_e;

  state_e     state;
  logic [7:0] collect;
  logic [7:0] col_next;
  logic [2:0] s_idx;

  // sync forces the incoming bit to slot 0 and restarts collection
  always_comb begin
    s_idx           = sync ? 3'd0 : state[2:0];
    col_next        = sync ? '0 : collect;
    col_next[s_idx] = din;
  end

`ifdef DEMUX_PARITY_EN
  // SP is not a data slot; report 0 there since the next data bit lands in slot 0
  assign slot = (state == SP) ? 3'd0 : state[2:0];
`else
  assign slot = state[2:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S0;
      y           <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      collect     <= '0;
    end else begin
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      if (din_valid) begin
`ifdef DEMUX_PARITY_EN
        if (state == SP && !sync) begin
          frame       <= collect;
          frame_valid <= 1'b1;
          parity_err  <= ^collect ^ din;
          collect     <= '0;
          state       <= S0;
        end else
`endif
        begin
          y[s_idx] <= din;
          collect  <= col_next;
          if (s_idx == 3'd7) begin
`ifdef DEMUX_PARITY_EN
            state <= SP;
`else
            frame       <= col_next;
            frame_valid <= 1'b1;
            collect     <= '0;
            state       <= S0;
`endif
          end else begin
            state <= state_e'(SW'(s_idx) + SW'(1));
          end
        end
      end else if (sync) begin
        state   <= S0;
        collect <= '0;
      end
    end
  end

endmodule

// File: tb/tb_demux1x8_tdm.sv
// Scoreboard testbench for demux1x8_tdm: directed frames plus random traffic
// against a slot/frame reference model; frames are checked by a separate monitor.
`timescale 1ns/1ps
module tb_demux1x8_tdm;

`ifdef DEMUX_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       sync = 1'b0;
  logic [7:0] y;
  logic [7:0] frame;
  logic       frame_valid;
  logic [2:0] slot;
  logic       parity_err;

  demux1x8_tdm dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .y(y), .frame(frame), .frame_valid(frame_valid), .slot(slot),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: next slot (8 = parity slot), live outputs, partial frame
  int         ref_slot = 0;
  logic [7:0] ref_y = '0;
  logic [7:0] bits = '0;

  logic [8:0] exp_f[$];
  longint     exp_t[$];
  longint     fv_t[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic perr);
    exp_f.push_back({perr, bits});
    exp_t.push_back($time + 5);
    bits = '0;
    ref_slot = 0;
  endtask

  task automatic step(input logic v, input logic s, input logic d);
    din_valid = v;
    sync = s;
    din = d;
    @(posedge clk);
    if (v) begin
      if (s) begin
        bits = '0;
        ref_slot = 0;
      end
      if (ref_slot == 8) begin
        push_frame(^bits ^ d);
      end else begin
        ref_y[ref_slot] = d;
        bits[ref_slot] = d;
        if (ref_slot == 7) begin
          if (FLEN == 9) ref_slot = 8;
          else push_frame(1'b0);
        end else begin
          ref_slot++;
        end
      end
    end else if (s) begin
      bits = '0;
      ref_slot = 0;
    end
    @(negedge clk);
    check("y", 32'(y), 32'(ref_y));
    check("slot", 32'(slot), (ref_slot == 8) ? 32'd0 : 32'(ref_slot));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] f, input int maxgap, input logic use_sync,
                            input logic sp_ok);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, use_sync && k == 0, f[k]);
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
    if (FLEN == 9) step(1'b1, 1'b0, sp_ok ? ^f : ~^f);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 1'($urandom);
    sync = 1'($urandom);
    din = 1'($urandom);
    @(posedge clk);
    ref_slot = 0;
    ref_y = '0;
    bits = '0;
    exp_f.delete();
    exp_t.delete();
    @(negedge clk);
    check("rst_y", 32'(y), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);
    check("rst_slot", 32'(slot), 32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    rst_n = 1'b1;
    din_valid = 1'b0;
    sync = 1'b0;
  endtask

  // monitor: pops expected frames whenever the DUT presents one
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid === 1'b1) begin
        if (exp_f.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_valid: got frame %0h expected no pulse at %0t", frame, $time);
        end else begin
          logic [8:0] e;
          longint     t;
          e = exp_f.pop_front();
          t = exp_t.pop_front();
          check("frame", 32'(frame), 32'(e[7:0]));
          check("parity_err", 32'(parity_err), 32'(e[8]));
          check("fv_latency", 32'($time), 32'(t));
          fv_t.push_back($time);
        end
      end else begin
        check("parity_err_idle", 32'(parity_err), 32'd0);
        if (exp_t.size() > 0 && exp_t[0] <= $time) begin
          checks++;
          errors++;
          $display("FAIL missed_frame_valid: got no pulse expected frame %0h at %0t", exp_f[0][7:0], $time);
          void'(exp_f.pop_front());
          void'(exp_t.pop_front());
        end
      end
    end
  end

  initial begin
    int n0;
    do_reset();

    // pattern 1,0,1,1,0,0,1,0 on slots 0..7
    send_frame(8'h4D, 0, 1'b1, 1'b1);
    idle(2);
    check("frame_4D", 32'(frame), 32'h4D);

    // same pattern with idle gaps and random din during gaps
    send_frame(8'h4D, 3, 1'b1, 1'b1);
    idle(2);
    check("frame_4D_gaps", 32'(frame), 32'h4D);

    // partial frame discarded by sync without valid
    for (int k = 0; k < 5; k++) step(1'b1, k == 0, 1'($urandom));
    step(1'b0, 1'b1, 1'b1);
    send_frame(8'hA5, 0, 1'b0, 1'b1);
    idle(2);
    check("frame_A5", 32'(frame), 32'hA5);

    // back-to-back frames with valid held high
    n0 = fv_t.size();
    send_frame(8'h3C, 0, 1'b1, 1'b1);
    send_frame(8'hFF, 0, 1'b0, 1'b1);
    idle(1);
    check("b2b_count", 32'(fv_t.size() - n0), 32'd2);
    if (fv_t.size() - n0 == 2)
      check("b2b_spacing", 32'(fv_t[n0+1] - fv_t[n0]), 32'(FLEN * 10));
    check("frame_FF", 32'(frame), 32'hFF);

    // reset mid-frame, then a frame starting at slot 0 without sync
    for (int k = 0; k < 5; k++) step(1'b1, k == 0, 1'($urandom));
    do_reset();
    send_frame(8'h81, 0, 1'b0, 1'b1);
    idle(2);
    check("frame_81", 32'(frame), 32'h81);

    // parity good then bad (no-op on parity slot in the default build)
    send_frame(8'h07, 0, 1'b1, 1'b1);
    send_frame(8'h07, 0, 1'b1, 1'b0);
    idle(2);

    // random traffic: valid gaps, occasional sync
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 1'($urandom));
    for (int i = 0; i < 10; i++) send_frame(8'($urandom), 2, 1'($urandom), 1'($urandom));
    idle(3);

    check("pending_frames", 32'(exp_f.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
